// File: rtl/wb_regfile_if.sv
// MEM/WB-to-register-file bundle: write-back sources, ID read ports and commit trace.
// The master side drives the pipeline register outputs and read addresses.
interface wb_regfile_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
);
  logic [2:0]    MemtoReg;
  logic          RegWrite;
  logic [AW-1:0] WReg;
  logic [DW-1:0] ALUS;
  logic [DW-1:0] dmOut;
  logic [DW-1:0] pc8;
  logic [DW-1:0] HILO;
  logic [DW-1:0] CP0Out;
  logic [2:0]    load_ext_op;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic [DW-1:0] wb_data;
  logic          trace_we;
  logic [AW-1:0] trace_addr;
  logic [DW-1:0] trace_data;
  logic [31:0]   commit_cnt;

  modport master (
    output MemtoReg, RegWrite, WReg, ALUS, dmOut, pc8, HILO, CP0Out, load_ext_op, ra1, ra2,
    input  rd1, rd2, wb_data, trace_we, trace_addr, trace_data, commit_cnt
  );

  modport slave (
    input  MemtoReg, RegWrite, WReg, ALUS, dmOut, pc8, HILO, CP0Out, load_ext_op, ra1, ra2,
    output rd1, rd2, wb_data, trace_we, trace_addr, trace_data, commit_cnt
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage: result mux with load extension, 32-entry GPR file with
// write-through read bypass, and a one-cycle-delayed commit trace.
module wb_regfile #(
  parameter int unsigned   DW      = 32,
  parameter int unsigned   AW      = 5,
  parameter logic [DW-1:0] GP_INIT = 32'h0000_1800,
  parameter logic [DW-1:0] SP_INIT = 32'h0000_2ffc
) (
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);

  localparam int unsigned NREG  = 2 ** AW;
  localparam int unsigned GP_IX = 28;
  localparam int unsigned SP_IX = 29;

  logic [DW-1:0] gpr [NREG];

  logic [7:0]    byte_c;
  logic [15:0]   half_c;
  logic [DW-1:0] load_c;
  logic [DW-1:0] wb_data_c;
  logic          commit_c;
  logic [DW-1:0] rd1_c;
  logic [DW-1:0] rd2_c;

  logic          trace_we_q;
  logic [AW-1:0] trace_addr_q;
  logic [DW-1:0] trace_data_q;
  logic [31:0]   cnt_q;

  // Little-endian lane select; ALUS[0] is ignored for halfwords.
  always_comb begin
    byte_c = bus.dmOut[7:0];
    case (bus.ALUS[1:0])
      2'd0:    byte_c = bus.dmOut[7:0];
      2'd1:    byte_c = bus.dmOut[15:8];
      2'd2:    byte_c = bus.dmOut[23:16];
      default: byte_c = bus.dmOut[31:24];
    endcase
    half_c = bus.ALUS[1] ? bus.dmOut[31:16] : bus.dmOut[15:0];
  end

  always_comb begin
    load_c = bus.dmOut;
    case (bus.load_ext_op)
      3'd1:    load_c = {{(DW-8){1'b0}}, byte_c};
      3'd2:    load_c = {{(DW-8){byte_c[7]}}, byte_c};
      3'd3:    load_c = {{(DW-16){1'b0}}, half_c};
      3'd4:    load_c = {{(DW-16){half_c[15]}}, half_c};
      default: load_c = bus.dmOut;
    endcase
  end

  always_comb begin
    wb_data_c = '0;
    case (bus.MemtoReg)
      3'd0:    wb_data_c = bus.ALUS;
      3'd1:    wb_data_c = load_c;
      3'd2:    wb_data_c = bus.pc8;
      3'd3:    wb_data_c = bus.HILO;
      3'd4:    wb_data_c = bus.CP0Out;
      default: wb_data_c = '0;
    endcase
  end

  assign commit_c = bus.RegWrite && (bus.WReg != '0);

  // Same-cycle write-through so ID sees a value being committed this cycle.
  always_comb begin
    rd1_c = gpr[bus.ra1];
    rd2_c = gpr[bus.ra2];
    if (bus.ra1 == '0) begin
      rd1_c = '0;
    end else if (commit_c && (bus.ra1 == bus.WReg)) begin
      rd1_c = wb_data_c;
    end
    if (bus.ra2 == '0) begin
      rd2_c = '0;
    end else if (commit_c && (bus.ra2 == bus.WReg)) begin
      rd2_c = wb_data_c;
    end
  end

  // GPR array; $0 is never written so it stays zero from reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        gpr[i] <= '0;
      end
      gpr[GP_IX] <= GP_INIT;
      gpr[SP_IX] <= SP_INIT;
    end else if (commit_c) begin
      gpr[bus.WReg] <= wb_data_c;
    end
  end

  // Commit trace and counter; address/data hold when nothing commits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trace_we_q   <= 1'b0;
      trace_addr_q <= '0;
      trace_data_q <= '0;
      cnt_q        <= '0;
    end else begin
      trace_we_q <= commit_c;
      if (commit_c) begin
        trace_addr_q <= bus.WReg;
        trace_data_q <= wb_data_c;
        cnt_q        <= cnt_q + 32'd1;
      end
    end
  end

  assign bus.rd1        = rd1_c;
  assign bus.rd2        = rd2_c;
  assign bus.wb_data    = wb_data_c;
  assign bus.trace_we   = trace_we_q;
  assign bus.trace_addr = trace_addr_q;
  assign bus.trace_data = trace_data_q;
  assign bus.commit_cnt = cnt_q;

endmodule
